// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared constants, FSM states and parity helper for fifo_uart
// Purpose: cfg/status bit positions, TX/RX state encodings, parity over 5..8 data bits.
package fifo_uart_pkg;

  localparam int CFG_EN      = 0;
  localparam int CFG_PAR_EN  = 1;
  localparam int CFG_PAR_ODD = 2;
  localparam int CFG_STOP2   = 3;
  localparam int CFG_NB_LO   = 4;
  localparam int CFG_NB_HI   = 5;
  localparam int CFG_RX_IRQ  = 6;
  localparam int CFG_TX_IRQ  = 7;

  localparam int STS_TX_FULL  = 0;
  localparam int STS_TX_EMPTY = 1;
  localparam int STS_RX_EMPTY = 2;
  localparam int STS_RX_FULL  = 3;
  localparam int STS_OVERRUN  = 4;
  localparam int STS_PAR_ERR  = 5;
  localparam int STS_FRM_ERR  = 6;
  localparam int STS_TX_BUSY  = 7;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Parity over the low (nsel+5) bits; odd parity is the inverse of the XOR.
  function automatic logic f_parity(input logic [7:0] d, input logic [1:0] nsel, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nsel) + 5) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_uart_if.sv
// rtl/fifo_uart_if.sv - register-strobe bus between host wrapper and fifo_uart
// Purpose: groups divider/config/data/status strobes; master = host, slave = UART.
interface fifo_uart_if #(parameter int DIV_W = 16);
  logic             reg_div_we;
  logic [DIV_W-1:0] reg_div_di;
  logic [DIV_W-1:0] reg_div_do;
  logic             reg_cfg_we;
  logic [7:0]       reg_cfg_di;
  logic [7:0]       reg_cfg_do;
  logic             reg_dat_we;
  logic [7:0]       reg_dat_di;
  logic             reg_dat_re;
  logic [7:0]       reg_dat_do;
  logic             reg_sts_clr;
  logic [7:0]       reg_sts_do;

  modport master (
    output reg_div_we, reg_div_di, reg_cfg_we, reg_cfg_di,
    output reg_dat_we, reg_dat_di, reg_dat_re, reg_sts_clr,
    input  reg_div_do, reg_cfg_do, reg_dat_do, reg_sts_do
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_cfg_we, reg_cfg_di,
    input  reg_dat_we, reg_dat_di, reg_dat_re, reg_sts_clr,
    output reg_div_do, reg_cfg_do, reg_dat_do, reg_sts_do
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with extra pointer bit for full/empty
// Ports: clk, resetn (sync, active-low), i_we/i_wdata push, i_re pop,
//        o_rdata head (combinational), o_full, o_empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_rd, w_do_wr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign w_do_rd = i_re && !o_empty;
  assign w_do_wr = i_we && (!o_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/fifo_uart.sv
// rtl/fifo_uart.sv - buffered UART with configurable framing, sticky errors and irq
// Ports: clk, resetn (sync, active-low), i_ser_rx async serial in, o_ser_tx serial out
//        (idle high), o_enabled = cfg enable, o_irq level interrupt, bus register strobes.
module fifo_uart
  import fifo_uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_ser_rx,
  output logic         o_ser_tx,
  output logic         o_enabled,
  output logic         o_irq,
  fifo_uart_if.slave   bus
);
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_cfg;
  logic [DIV_W-1:0] w_div_eff, w_half;
  logic             w_en;
  logic [2:0]       w_last_bit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div <= DIV_ONE;
      r_cfg <= 8'h00;
    end else begin
      if (bus.reg_div_we) r_div <= bus.reg_div_di;
      if (bus.reg_cfg_we) r_cfg <= bus.reg_cfg_di;
    end
  end

  // Divider 0 behaves as 1, giving a minimum bit period of two cycles.
  assign w_div_eff  = (r_div == '0) ? DIV_ONE : r_div;
  assign w_half     = w_div_eff >> 1;
  assign w_en       = r_cfg[CFG_EN];
  assign w_last_bit = {1'b0, r_cfg[CFG_NB_HI:CFG_NB_LO]} + 3'd4;

  // ---------------- TX ----------------
  logic       w_tx_pop, w_tx_full, w_tx_empty, w_tx_line, w_tx_tick;
  logic [7:0] w_tx_head;
  tx_state_t  r_tx_state, w_tx_state_nx;
  logic [DIV_W-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0] r_tx_bit, w_tx_bit_nx;
  logic [7:0] r_tx_byte, w_tx_byte_nx;
  logic       r_ser_tx;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn),
    .i_we(bus.reg_dat_we), .i_wdata(bus.reg_dat_di), .i_re(w_tx_pop),
    .o_rdata(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  assign w_tx_tick = (r_tx_cnt >= w_div_eff);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = w_tx_tick ? '0 : r_tx_cnt + DIV_ONE;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_byte_nx  = r_tx_byte;
    w_tx_pop      = 1'b0;
    w_tx_line     = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        if (w_en && !w_tx_empty) begin
          w_tx_pop      = 1'b1;
          w_tx_byte_nx  = w_tx_head;
          w_tx_bit_nx   = '0;
          w_tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_tick) begin
          w_tx_bit_nx   = '0;
          w_tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        w_tx_line = r_tx_byte[r_tx_bit];
        if (w_tx_tick) begin
          w_tx_bit_nx = r_tx_bit + 3'd1;
          if (r_tx_bit == w_last_bit) begin
            w_tx_bit_nx   = '0;
            w_tx_state_nx = r_cfg[CFG_PAR_EN] ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        w_tx_line = f_parity(r_tx_byte, r_cfg[CFG_NB_HI:CFG_NB_LO], r_cfg[CFG_PAR_ODD]);
        if (w_tx_tick) begin
          w_tx_bit_nx   = '0;
          w_tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        // r_tx_bit counts stop bits here; the next frame starts with no idle gap.
        if (w_tx_tick) begin
          if (r_cfg[CFG_STOP2] && r_tx_bit == 3'd0) begin
            w_tx_bit_nx = 3'd1;
          end else if (w_en && !w_tx_empty) begin
            w_tx_pop      = 1'b1;
            w_tx_byte_nx  = w_tx_head;
            w_tx_bit_nx   = '0;
            w_tx_state_nx = TX_START;
          end else begin
            w_tx_state_nx = TX_IDLE;
          end
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_byte  <= '0;
      r_ser_tx   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_byte  <= w_tx_byte_nx;
      r_ser_tx   <= w_tx_line;
    end
  end

  // ---------------- RX ----------------
  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  logic       w_rx_full, w_rx_empty, w_rx_tick;
  logic [7:0] w_rx_head;
  rx_state_t  r_rx_state, w_rx_state_nx;
  logic [DIV_W-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0] r_rx_bit, w_rx_bit_nx;
  logic [7:0] r_rx_byte, w_rx_byte_nx;
  logic       r_rx_pbit, w_rx_pbit_nx;
  logic       r_rx_push, w_rx_push_nx;
  logic       r_rx_perr, w_rx_perr_nx;
  logic       r_rx_ferr, w_rx_ferr_nx;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn),
    .i_we(r_rx_push), .i_wdata(r_rx_byte), .i_re(bus.reg_dat_re),
    .o_rdata(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign w_rx_tick = (r_rx_cnt >= w_div_eff);

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = w_rx_tick ? '0 : r_rx_cnt + DIV_ONE;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_byte_nx  = r_rx_byte;
    w_rx_pbit_nx  = r_rx_pbit;
    w_rx_push_nx  = 1'b0;
    w_rx_perr_nx  = r_rx_perr;
    w_rx_ferr_nx  = r_rx_ferr;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = '0;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_byte_nx  = '0;
          w_rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        // Re-check the line mid start bit to reject glitches; data then sampled at centres.
        w_rx_cnt_nx = r_rx_cnt + DIV_ONE;
        if (r_rx_cnt >= w_half) begin
          w_rx_cnt_nx   = '0;
          w_rx_bit_nx   = '0;
          w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_byte_nx[r_rx_bit] = r_rx_s2;
          w_rx_bit_nx = r_rx_bit + 3'd1;
          if (r_rx_bit == w_last_bit)
            w_rx_state_nx = r_cfg[CFG_PAR_EN] ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (w_rx_tick) begin
          w_rx_pbit_nx  = r_rx_s2;
          w_rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        // Only the first stop bit is checked; IDLE tolerates the second.
        if (w_rx_tick) begin
          w_rx_push_nx  = 1'b1;
          w_rx_ferr_nx  = !r_rx_s2;
          w_rx_perr_nx  = r_cfg[CFG_PAR_EN] &&
                          (r_rx_pbit != f_parity(r_rx_byte, r_cfg[CFG_NB_HI:CFG_NB_LO], r_cfg[CFG_PAR_ODD]));
          w_rx_state_nx = RX_IDLE;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
    if (!w_en) begin
      w_rx_state_nx = RX_IDLE;
      w_rx_push_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_push  <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= i_ser_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_byte  <= w_rx_byte_nx;
      r_rx_pbit  <= w_rx_pbit_nx;
      r_rx_push  <= w_rx_push_nx;
      r_rx_perr  <= w_rx_perr_nx;
      r_rx_ferr  <= w_rx_ferr_nx;
    end
  end

  // ---------------- sticky flags / outputs ----------------
  logic r_overrun, r_par_err, r_frm_err;
  logic w_set_ovr, w_set_par, w_set_frm;

  // A pop in the push cycle makes room, so that case is not an overrun.
  assign w_set_ovr = r_rx_push && w_rx_full && !bus.reg_dat_re;
  assign w_set_par = r_rx_push && r_rx_perr;
  assign w_set_frm = r_rx_push && r_rx_ferr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overrun <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_set_ovr) r_overrun <= 1'b1; else if (bus.reg_sts_clr) r_overrun <= 1'b0;
      if (w_set_par) r_par_err <= 1'b1; else if (bus.reg_sts_clr) r_par_err <= 1'b0;
      if (w_set_frm) r_frm_err <= 1'b1; else if (bus.reg_sts_clr) r_frm_err <= 1'b0;
    end
  end

  assign o_ser_tx       = r_ser_tx;
  assign o_enabled      = w_en;
  assign bus.reg_div_do = r_div;
  assign bus.reg_cfg_do = r_cfg;
  assign bus.reg_dat_do = w_rx_empty ? 8'hFF : w_rx_head;
  assign bus.reg_sts_do = {(r_tx_state != TX_IDLE), r_frm_err, r_par_err, r_overrun,
                           w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
  assign o_irq = (r_cfg[CFG_RX_IRQ] & (!w_rx_empty | r_overrun | r_par_err | r_frm_err)) |
                 (r_cfg[CFG_TX_IRQ] & w_tx_empty);
endmodule

// File: tb/tb_fifo_uart.sv
// tb/tb_fifo_uart.sv - scoreboard testbench for fifo_uart
module tb_fifo_uart;
  import fifo_uart_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  logic ser_tx, enabled, irq;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_if #(.DIV_W(16)) bus ();

  fifo_uart #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .i_ser_rx(ser_rx), .o_ser_tx(ser_tx),
    .o_enabled(enabled), .o_irq(irq), .bus(bus)
  );

  int txq[$];
  int rxq[$];
  int tx_starts[$];
  bit rx_auto = 1'b0;

  int m_bitp = 2, m_nb = 5, m_stops = 1;
  bit m_par = 1'b0, m_odd = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_par(input logic [7:0] d, input int nb, input bit odd);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return bit'(ones % 2) ^ odd;
  endfunction

  function automatic int mask(input logic [7:0] d);
    return int'(d) & ((1 << m_nb) - 1);
  endfunction

  task automatic set_div(input logic [15:0] v);
    @(negedge clk); bus.reg_div_di = v; bus.reg_div_we = 1'b1;
    @(negedge clk); bus.reg_div_we = 1'b0;
    m_bitp = ((v == 16'd0) ? 1 : int'(v)) + 1;
  endtask

  task automatic set_cfg(input logic [7:0] c);
    @(negedge clk); bus.reg_cfg_di = c; bus.reg_cfg_we = 1'b1;
    @(negedge clk); bus.reg_cfg_we = 1'b0;
    m_nb = 5 + int'(c[5:4]); m_par = c[1]; m_odd = c[2]; m_stops = c[3] ? 2 : 1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    @(negedge clk); bus.reg_dat_di = b; bus.reg_dat_we = 1'b1;
    @(negedge clk); bus.reg_dat_we = 1'b0;
  endtask

  task automatic sts_clr();
    @(negedge clk); bus.reg_sts_clr = 1'b1;
    @(negedge clk); bus.reg_sts_clr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit flip, input bit stop0);
    @(negedge clk); ser_rx = 1'b0; repeat (m_bitp) @(negedge clk);
    for (int i = 0; i < m_nb; i++) begin ser_rx = d[i]; repeat (m_bitp) @(negedge clk); end
    if (m_par) begin ser_rx = model_par(d, m_nb, m_odd) ^ flip; repeat (m_bitp) @(negedge clk); end
    for (int s = 0; s < m_stops; s++) begin
      ser_rx = (s == 0) ? !stop0 : 1'b1; repeat (m_bitp) @(negedge clk);
    end
    ser_rx = 1'b1; repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while ((txq.size() != 0 || bus.reg_sts_do[STS_TX_BUSY]) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("tx_timeout", int'(n < budget), 1);
  endtask

  task automatic wait_rx_drain(input int budget);
    int n = 0;
    while (rxq.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("rx_timeout", int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // TX monitor: decodes frames on ser_tx at bit centres, checks against txq.
  initial begin : tx_mon
    int prev, d;
    prev = 1;
    forever begin
      @(negedge clk);
      if (prev == 1 && ser_tx == 1'b0) begin
        tx_starts.push_back(cyc);
        repeat (m_bitp / 2) @(negedge clk);
        chk("tx_start_bit", int'(ser_tx), 0);
        d = 0;
        for (int i = 0; i < m_nb; i++) begin
          repeat (m_bitp) @(negedge clk);
          d = d | (int'(ser_tx) << i);
        end
        if (m_par) begin
          repeat (m_bitp) @(negedge clk);
          chk("tx_parity", int'(ser_tx), int'(model_par(d[7:0], m_nb, m_odd)));
        end
        for (int s = 0; s < m_stops; s++) begin
          repeat (m_bitp) @(negedge clk);
          chk("tx_stop", int'(ser_tx), 1);
        end
        if (txq.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=0x%0h required=none", d);
        end else begin
          chk("tx_byte", d, txq.pop_front());
        end
        prev = 1;
      end else begin
        prev = int'(ser_tx);
      end
    end
  end

  // RX monitor: pops the RX FIFO whenever it holds data and compares with rxq.
  initial begin : rx_mon
    bus.reg_dat_re = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_auto && !bus.reg_sts_do[STS_RX_EMPTY]) begin
        if (rxq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_unexpected actual=0x%0h required=none", bus.reg_dat_do);
        end else begin
          chk("rx_byte", int'(bus.reg_dat_do), rxq.pop_front());
        end
        bus.reg_dat_re = 1'b1;
        @(negedge clk);
        bus.reg_dat_re = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [7:0] b, b2, c;
    logic [9:0] fr;
    int idx;
    bus.reg_div_we = 0; bus.reg_div_di = '0; bus.reg_cfg_we = 0; bus.reg_cfg_di = '0;
    bus.reg_dat_we = 0; bus.reg_dat_di = '0; bus.reg_sts_clr = 0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_sts", int'(bus.reg_sts_do), 8'h06);
    chk("rst_ser_tx", int'(ser_tx), 1);
    chk("rst_irq", int'(irq), 0);
    chk("rst_div", int'(bus.reg_div_do), 1);
    chk("rst_cfg", int'(bus.reg_cfg_do), 0);
    chk("rst_dat", int'(bus.reg_dat_do), 8'hFF);

    // 8N1 at divider 4: exact waveform from edge N.
    set_div(16'd4);
    set_cfg(8'h31);
    chk("cfg_readback", int'(bus.reg_cfg_do), 8'h31);
    chk("div_readback", int'(bus.reg_div_do), 4);
    chk("enabled", int'(enabled), 1);
    txq.push_back(8'hA5);
    tx_push(8'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      idx = (k - 2) / 5;
      chk("tx_wave", int'(ser_tx), (k < 2) ? 1 : int'(fr[idx]));
    end
    wait_tx_idle(500);

    // Fill TX FIFO while disabled, then release: 8 back-to-back frames.
    set_cfg(8'h30);
    tx_starts.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) txq.push_back(int'(b));
      tx_push(b);
      if (i == 6) chk("tx_not_full", int'(bus.reg_sts_do[STS_TX_FULL]), 0);
      if (i >= 7) chk("tx_full", int'(bus.reg_sts_do[STS_TX_FULL]), 1);
    end
    set_cfg(8'h31);
    wait_tx_idle(2000);
    repeat (100) @(negedge clk);
    chk("tx_frames", tx_starts.size(), 8);
    for (int i = 1; i < tx_starts.size(); i++)
      chk("tx_gap", tx_starts[i] - tx_starts[i-1], 10 * m_bitp);

    // 7 data bits, odd parity, 2 stops, wrong parity bit.
    set_div(16'd15);
    set_cfg(8'h6F);
    rx_auto = 1'b0;
    rxq.push_back(8'h35);
    send_rx(8'h35, 1'b1, 1'b0);
    chk("perr_data", int'(bus.reg_dat_do), 8'h35);
    chk("perr_flag", int'(bus.reg_sts_do[STS_PAR_ERR]), 1);
    chk("perr_no_ferr", int'(bus.reg_sts_do[STS_FRM_ERR]), 0);
    chk("perr_irq", int'(irq), 1);
    rx_auto = 1'b1;
    wait_rx_drain(500);
    sts_clr();
    chk("perr_clr", int'(bus.reg_sts_do[STS_PAR_ERR]), 0);
    chk("irq_clear", int'(irq), 0);

    // 9 frames with no reads: first 8 kept, overrun set.
    set_cfg(8'h71);
    rx_auto = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) rxq.push_back(int'(b));
      send_rx(b, 1'b0, 1'b0);
    end
    chk("rx_full", int'(bus.reg_sts_do[STS_RX_FULL]), 1);
    chk("overrun", int'(bus.reg_sts_do[STS_OVERRUN]), 1);
    rx_auto = 1'b1;
    wait_rx_drain(2000);
    chk("rx_drained", int'(bus.reg_sts_do[STS_RX_EMPTY]), 1);
    sts_clr();
    chk("overrun_clr", int'(bus.reg_sts_do[STS_OVERRUN]), 0);

    // Short start glitch, then a frame with a low stop bit.
    rx_auto = 1'b0;
    @(negedge clk); ser_rx = 1'b0;
    repeat (4) @(negedge clk); ser_rx = 1'b1;
    repeat (3 * m_bitp) @(negedge clk);
    chk("glitch_no_push", int'(bus.reg_sts_do[STS_RX_EMPTY]), 1);
    b = 8'($urandom);
    rxq.push_back(int'(b));
    send_rx(b, 1'b0, 1'b1);
    chk("ferr_flag", int'(bus.reg_sts_do[STS_FRM_ERR]), 1);
    rx_auto = 1'b1;
    wait_rx_drain(500);
    sts_clr();
    chk("ferr_clr", int'(bus.reg_sts_do[STS_FRM_ERR]), 0);

    // Disable mid TX frame: current frame completes, next stays queued.
    set_div(16'd4);
    set_cfg(8'h31);
    tx_starts.delete();
    b = 8'($urandom); b2 = 8'($urandom);
    txq.push_back(int'(b));
    tx_push(b);
    tx_push(b2);
    repeat (20) @(negedge clk);
    set_cfg(8'h30);
    wait_tx_idle(500);
    repeat (100) @(negedge clk);
    chk("tx_halt_frames", tx_starts.size(), 1);
    chk("tx_halt_kept", int'(bus.reg_sts_do[STS_TX_EMPTY]), 0);

    // Re-enable (queued byte goes out), disable mid RX frame: no push.
    txq.push_back(int'(b2));
    set_cfg(8'h31);
    fork
      send_rx(8'h5A, 1'b0, 1'b0);
      begin repeat (4 * m_bitp) @(negedge clk); set_cfg(8'h30); end
    join
    repeat (10) @(negedge clk);
    chk("rx_abort_no_push", int'(bus.reg_sts_do[STS_RX_EMPTY]), 1);
    wait_tx_idle(500);

    // Random framing: TX and RX in the same configuration.
    for (int it = 0; it < 4; it++) begin
      c = 8'h01 | 8'($urandom_range(0, 1) << 1) | 8'($urandom_range(0, 1) << 2) |
          8'($urandom_range(0, 1) << 3) | 8'($urandom_range(0, 3) << 4);
      set_div(16'($urandom_range(2, 6)));
      set_cfg(c);
      b = 8'($urandom);
      txq.push_back(mask(b));
      tx_push(b);
      rxq.push_back(mask(b));
      send_rx(b, 1'b0, 1'b0);
      wait_tx_idle(1000);
      wait_rx_drain(1000);
    end
    chk("rand_no_errs", int'(bus.reg_sts_do[6:4]), 0);

    // TX interrupt follows tx_empty when enabled.
    set_cfg(8'h80);
    chk("tx_irq", int'(irq), 1);
    chk("disabled", int'(enabled), 0);
    set_cfg(8'h00);
    chk("irq_off", int'(irq), 0);

    chk("txq_empty", txq.size(), 0);
    chk("rxq_empty", rxq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
